// File: rtl/compressed_line_packer.sv
// ============================================================================
// compressed_line_packer
//
// Gathers compressed (data, zero-run index) pairs from the PPU compression
// stage into a circular staging buffer. Emits fixed-width lines of LINE
// entries to the output-activation buffer write port over a valid/ready
// handshake. A per-channel flush drains the partial tail and flags it last.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      per-lane valid, thermometer from lane 0
//   in_data       lane data, lane i at [i*DATA_W +: DATA_W]
//   in_idx        lane zero-run index, lane i at [i*IDX_W +: IDX_W]
//   in_flush      end of channel, takes effect after this cycle's lanes
//   in_ready      packer can accept this cycle
//   line_valid    output line present
//   line_ready    consumer accepts the line
//   line_data     line entries, entry 0 = oldest
//   line_idx      indices aligned with line_data
//   line_count    valid entries in the line (0..LINE)
//   line_last     final line of the channel
//   line_addr     line number within the channel
//
// Optional build macro PACKER_STATS_EN adds saturating 32-bit counters:
//   stat_entries  total entries popped
//   stat_stall    cycles with input offered while not ready
//   stat_bp       cycles with a line presented but not accepted
// ============================================================================
module compressed_line_packer #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int LINE   = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        in_valid,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN*IDX_W-1:0]  in_idx,
    input  logic                   in_flush,
    output logic                   in_ready,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic [LINE*DATA_W-1:0] line_data,
    output logic [LINE*IDX_W-1:0]  line_idx,
    output logic [$clog2(LINE):0]  line_count,
    output logic                   line_last,
    output logic [ADDR_W-1:0]      line_addr
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]            stat_entries,
    output logic [31:0]            stat_stall,
    output logic [31:0]            stat_bp
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int CNT_W  = $clog2(LINE) + 1;
    localparam int LANE_W = $clog2(N_IN) + 1;

    typedef enum logic {
        ACCEPT = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [IDX_W-1:0]  idx_mem  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  occ;
    logic [ADDR_W-1:0] addr;

    logic [LANE_W-1:0] take_count;
    logic              take_run;
    logic              fire;
    logic              pop;
    int                line_cnt;
    int                push_cnt;
    int                pop_cnt;

    // Circular-buffer index arithmetic. Offsets never exceed DEPTH, so a
    // single conditional subtract is enough and DEPTH need not be a power
    // of two.
    function automatic logic [PTR_W-1:0] wrap(input int base, input int off);
        int sum;
        sum = base + off;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return PTR_W'(sum);
    endfunction

    // Count the contiguous run of valid lanes starting at lane 0. Lanes
    // above the first gap are dropped, which keeps a malformed in_valid
    // from leaving holes in the buffer.
    always_comb begin
        take_count = '0;
        take_run   = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (take_run && in_valid[i]) begin
                take_count = take_count + LANE_W'(1);
            end else begin
                take_run = 1'b0;
            end
        end
    end

    // Next-state and output decode. Line outputs depend only on registered
    // buffer state, so they cannot glitch with in_* and they hold steady
    // while the consumer stalls.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        line_valid = 1'b0;
        line_last  = 1'b0;
        line_cnt   = (int'(occ) >= LINE) ? LINE : int'(occ);
        line_count = CNT_W'(line_cnt);
        line_addr  = addr;
        line_data  = '0;
        line_idx   = '0;
        fire       = 1'b0;
        pop        = 1'b0;
        push_cnt   = 0;
        pop_cnt    = 0;

        for (int k = 0; k < LINE; k++) begin
            if (k < line_cnt) begin
                line_data[k*DATA_W +: DATA_W] = data_mem[wrap(int'(head), k)];
                line_idx[k*IDX_W +: IDX_W]    = idx_mem[wrap(int'(head), k)];
            end
        end

        case (state)
            ACCEPT: begin
                in_ready   = (int'(occ) + N_IN <= DEPTH);
                line_valid = (int'(occ) >= LINE);
                fire       = in_ready && ((|in_valid) || in_flush);
                if (fire && in_flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Drain emits every remaining line, including a zero-count
                // channel-end marker when the buffer was already empty.
                line_valid = 1'b1;
                line_last  = (int'(occ) <= LINE);
                if (line_ready && line_last) begin
                    state_next = ACCEPT;
                end
            end
            default: begin
                state_next = ACCEPT;
            end
        endcase

        pop = line_valid && line_ready;
        if (fire) begin
            push_cnt = int'(take_count);
        end
        if (pop) begin
            pop_cnt = line_cnt;
        end
    end

    // State register plus pointer, occupancy and line-number bookkeeping.
    // A push and a pop in the same cycle both take effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            addr  <= '0;
        end else begin
            state <= state_next;
            tail  <= wrap(int'(tail), push_cnt);
            head  <= wrap(int'(head), pop_cnt);
            occ   <= OCC_W'(int'(occ) + push_cnt - pop_cnt);
            if (pop) begin
                if (line_last) begin
                    addr <= '0;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

    // Staging storage. Left unreset on purpose: entries beyond occ are
    // never exposed because the read mux zeroes lanes at or above
    // line_count.
    always_ff @(posedge clk) begin
        if (!rst && fire) begin
            for (int i = 0; i < N_IN; i++) begin
                if (i < int'(take_count)) begin
                    data_mem[wrap(int'(tail), i)] <= in_data[i*DATA_W +: DATA_W];
                    idx_mem[wrap(int'(tail), i)]  <= in_idx[i*IDX_W +: IDX_W];
                end
            end
        end
    end

`ifdef PACKER_STATS_EN
    logic [32:0] entries_sum;

    assign entries_sum = {1'b0, stat_entries} + 33'(pop_cnt);

    // Saturating statistics counters; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_entries <= '0;
            stat_stall   <= '0;
            stat_bp      <= '0;
        end else begin
            stat_entries <= entries_sum[32] ? 32'hFFFF_FFFF : entries_sum[31:0];
            if ((|in_valid) && !in_ready && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (line_valid && !line_ready && (stat_bp != 32'hFFFF_FFFF)) begin
                stat_bp <= stat_bp + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_compressed_line_packer.sv
// ============================================================================
// tb_compressed_line_packer
//
// Directed scenarios followed by randomized traffic for compressed_line_packer.
// A queue-based reference model tracks buffered entries, drain mode and the
// line number. Every cycle all DUT outputs are compared against it.
// ============================================================================
module tb_compressed_line_packer;

    localparam int N_IN   = 4;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;
    localparam int LINE   = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN*IDX_W-1:0]  in_idx;
    logic                   in_flush;
    logic                   in_ready;
    logic                   line_valid;
    logic                   line_ready;
    logic [LINE*DATA_W-1:0] line_data;
    logic [LINE*IDX_W-1:0]  line_idx;
    logic [$clog2(LINE):0]  line_count;
    logic                   line_last;
    logic [ADDR_W-1:0]      line_addr;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  x;
    } entry_t;

    entry_t model_q[$];
    bit     model_drain;
    int     model_addr;

    int assert_count = 0;
    int fail_count   = 0;

    compressed_line_packer #(
        .N_IN(N_IN), .DATA_W(DATA_W), .IDX_W(IDX_W),
        .LINE(LINE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_idx(in_idx),
        .in_flush(in_flush), .in_ready(in_ready),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_idx(line_idx),
        .line_count(line_count), .line_last(line_last),
        .line_addr(line_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h required %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Expected line view derived from the model queue.
    task automatic compareAll();
        int                     n;
        int                     cnt;
        logic                   exp_ready;
        logic                   exp_valid;
        logic                   exp_last;
        logic [LINE*DATA_W-1:0] exp_data;
        logic [LINE*IDX_W-1:0]  exp_idx;
        n         = model_q.size();
        cnt       = (n < LINE) ? n : LINE;
        exp_ready = !model_drain && (n + N_IN <= DEPTH);
        exp_valid = model_drain || (n >= LINE);
        exp_last  = model_drain && (n <= LINE);
        exp_data  = '0;
        exp_idx   = '0;
        for (int k = 0; k < cnt; k++) begin
            exp_data[k*DATA_W +: DATA_W] = model_q[k].d;
            exp_idx[k*IDX_W +: IDX_W]    = model_q[k].x;
        end
        checkOutput("in_ready",   256'(in_ready),   256'(exp_ready));
        checkOutput("line_valid", 256'(line_valid), 256'(exp_valid));
        checkOutput("line_count", 256'(line_count), 256'(cnt));
        checkOutput("line_last",  256'(line_last),  256'(exp_last));
        checkOutput("line_addr",  256'(line_addr),  256'(model_addr));
        checkOutput("line_data",  256'(line_data),  256'(exp_data));
        checkOutput("line_idx",   256'(line_idx),   256'(exp_idx));
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the
    // model by the same cycle, and move to the next falling edge.
    task automatic applyStimulus(input logic [N_IN-1:0] v,
                                 input logic [N_IN*DATA_W-1:0] d,
                                 input logic [N_IN*IDX_W-1:0] x,
                                 input logic f, input logic lr);
        int   n;
        int   cnt;
        logic rdy;
        logic vld;
        logic last;
        logic run;
        entry_t e;
        in_valid   = v;
        in_data    = d;
        in_idx     = x;
        in_flush   = f;
        line_ready = lr;
        n    = model_q.size();
        cnt  = (n < LINE) ? n : LINE;
        rdy  = !model_drain && (n + N_IN <= DEPTH);
        vld  = model_drain || (n >= LINE);
        last = model_drain && (n <= LINE);
        if (vld && lr) begin
            repeat (cnt) void'(model_q.pop_front());
            if (last) begin
                model_addr  = 0;
                model_drain = 0;
            end else begin
                model_addr = (model_addr + 1) % (1 << ADDR_W);
            end
        end
        if (rdy && ((v != '0) || f)) begin
            run = 1'b1;
            for (int l = 0; l < N_IN; l++) begin
                if (run && v[l]) begin
                    e.d = d[l*DATA_W +: DATA_W];
                    e.x = x[l*IDX_W +: IDX_W];
                    model_q.push_back(e);
                end else begin
                    run = 1'b0;
                end
            end
            if (f) begin
                model_drain = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [N_IN-1:0] v, input logic f, input logic lr);
        logic [N_IN*DATA_W-1:0] d;
        logic [N_IN*IDX_W-1:0]  x;
        for (int l = 0; l < N_IN; l++) begin
            d[l*DATA_W +: DATA_W] = DATA_W'($urandom);
            x[l*IDX_W +: IDX_W]   = IDX_W'($urandom);
        end
        compareAll();
        applyStimulus(v, d, x, f, lr);
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        in_valid   = '0;
        in_data    = '0;
        in_idx     = '0;
        in_flush   = 1'b0;
        line_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_drain = 0;
        model_addr  = 0;
    endtask

    initial begin
        logic [N_IN*DATA_W-1:0] d;
        logic [N_IN*IDX_W-1:0]  x;
        logic [LINE*DATA_W-1:0] exp_line;
        logic [N_IN-1:0]        v;

        applyReset();
        checkOutput("reset_valid", 256'(line_valid), 256'(0));
        checkOutput("reset_ready", 256'(in_ready),   256'(1));
        checkOutput("reset_count", 256'(line_count), 256'(0));
        checkOutput("reset_data",  256'(line_data),  256'(0));

        // Steady stream of 16 entries carrying data 1..16.
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < N_IN; l++) begin
                d[l*DATA_W +: DATA_W] = DATA_W'(c * N_IN + l + 1);
                x[l*IDX_W +: IDX_W]   = IDX_W'(l + c);
            end
            if (c == 2) begin
                for (int k = 0; k < LINE; k++) exp_line[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
                checkOutput("steady_line0_data", 256'(line_data), 256'(exp_line));
                checkOutput("steady_line0_addr", 256'(line_addr), 256'(0));
            end
            compareAll();
            applyStimulus(4'b1111, d, x, 1'b0, 1'b1);
        end
        for (int k = 0; k < LINE; k++) exp_line[k*DATA_W +: DATA_W] = DATA_W'(k + 9);
        checkOutput("steady_line1_data", 256'(line_data),  256'(exp_line));
        checkOutput("steady_line1_addr", 256'(line_addr),  256'(1));
        checkOutput("steady_line1_last", 256'(line_last),  256'(0));
        repeat (3) step(4'b0000, 1'b0, 1'b1);

        // Empty flush: channel-end marker only.
        step(4'b0000, 1'b1, 1'b0);
        checkOutput("empty_flush_valid", 256'(line_valid), 256'(1));
        checkOutput("empty_flush_count", 256'(line_count), 256'(0));
        checkOutput("empty_flush_last",  256'(line_last),  256'(1));
        step(4'b0000, 1'b0, 1'b1);

        // Partial tail flush of three entries.
        step(4'b0111, 1'b1, 1'b1);
        checkOutput("tail_ready", 256'(in_ready),   256'(0));
        checkOutput("tail_count", 256'(line_count), 256'(3));
        checkOutput("tail_last",  256'(line_last),  256'(1));
        checkOutput("tail_addr",  256'(line_addr),  256'(0));
        checkOutput("tail_zero_upper", 256'(line_data[LINE*DATA_W-1:3*DATA_W]), 256'(0));
        step(4'b0000, 1'b0, 1'b1);
        checkOutput("tail_back_ready", 256'(in_ready), 256'(1));

        // Backpressure until the buffer is full, then release.
        repeat (6) step(4'b1111, 1'b0, 1'b0);
        checkOutput("bp_full_ready", 256'(in_ready), 256'(0));
        repeat (4) step(4'b0000, 1'b0, 1'b1);

        // Close the channel so the next one starts at line 0.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1);

        // Flush spanning two lines: 10 buffered plus 2 with the flush.
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        checkOutput("span_first_count", 256'(line_count), 256'(8));
        checkOutput("span_first_last",  256'(line_last),  256'(0));
        checkOutput("span_first_addr",  256'(line_addr),  256'(0));
        step(4'b0000, 1'b0, 1'b1);
        checkOutput("span_second_count", 256'(line_count), 256'(4));
        checkOutput("span_second_last",  256'(line_last),  256'(1));
        checkOutput("span_second_addr",  256'(line_addr),  256'(1));
        step(4'b0000, 1'b0, 1'b1);

        // Reset in the middle of a drain holding five entries.
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        checkOutput("middrain_valid", 256'(line_valid), 256'(1));
        applyReset();
        checkOutput("postreset_valid", 256'(line_valid), 256'(0));
        checkOutput("postreset_ready", 256'(in_ready),   256'(1));
        checkOutput("postreset_addr",  256'(line_addr),  256'(0));
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        checkOutput("postreset_line_valid", 256'(line_valid), 256'(1));
        checkOutput("postreset_line_addr",  256'(line_addr),  256'(0));
        step(4'b0000, 1'b0, 1'b1);

        // Randomized traffic, including occasional non-contiguous valids.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                v = N_IN'($urandom);
            end else begin
                v = N_IN'((1 << $urandom_range(0, N_IN)) - 1);
            end
            step(v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end
        repeat (6) step(4'b0000, 1'b0, 1'b1);
        compareAll();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/compressed_line_packer.md
Name: compressed_line_packer

Overview:
- Sits directly downstream of the PPU compression stage.
- Each cycle it takes up to N_IN compressed (data, zero-run index) pairs, packed at low lanes, and gathers them into a staging buffer.
- It emits fixed-width lines of LINE entries to the output-activation buffer write port over a valid/ready handshake.
- A per-channel flush drains the partial tail line and marks it last.

Parameters:
- N_IN, 4, input lanes per cycle (matches pooling output width).
- DATA_W, 16, data width per entry.
- IDX_W, 4, zero-run index width per entry.
- LINE, 8, entries per output line; must be >= N_IN.
- DEPTH, 16, staging buffer entries; must be >= LINE + N_IN.
- ADDR_W, 10, line address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  N_IN  per-lane valid; contiguous from lane 0 (thermometer)
- in_data  in  N_IN*DATA_W  lane data
- in_idx  in  N_IN*IDX_W  lane zero-run index
- in_flush  in  1  end of channel; applies after this cycle's lanes
- in_ready  out  1  packer can accept this cycle
- line_valid  out  1  output line present
- line_ready  in  1  consumer accepts line
- line_data  out  LINE*DATA_W  entries, entry 0 = oldest
- line_idx  out  LINE*IDX_W  indices aligned to line_data
- line_count  out  $clog2(LINE)+1  valid entries in line (0..LINE)
- line_last  out  1  final line of channel
- line_addr  out  ADDR_W  line number within channel

Behaviour:
- Input fire = in_ready & (|in_valid | in_flush). A cycle with in_valid == 0 and in_flush == 0 has no effect.
- Non-contiguous in_valid is a protocol error; only the lanes below the first 0 are taken.
- FSM states ACCEPT and DRAIN.
- ACCEPT:
  - in_ready = (occ + N_IN <= DEPTH).
  - On fire, valid lanes are appended in lane order at the tail; occ += popcount(in_valid).
  - If in_flush fires, next state is DRAIN.
- DRAIN:
  - in_ready = 0.
  - Returns to ACCEPT the cycle after the last-flagged line handshakes.
- Line output:
  - line_valid = 1 when occ >= LINE, or when in DRAIN.
  - line_count = min(occ, LINE). Entries at or above line_count read 0.
  - line_last = 1 only in DRAIN when occ <= LINE.
  - Handshake on line_valid & line_ready pops line_count entries from the head.
  - line_data/line_idx/line_count/line_last hold stable while line_valid & !line_ready.
- Latency: an entry written at edge t is visible in a line from cycle t+1 (registered buffer; line outputs are combinational from buffer state).
- Simultaneous push and pop in one cycle are both honoured; occ_next = occ + pushed - popped.
- Flush with occ == 0 at DRAIN entry: one line with line_count = 0, line_last = 1 (channel-end marker).
- line_addr:
  - Starts at 0 per channel and increments on each line handshake.
  - Resets to 0 after the last line handshakes.
  - Wraps modulo 2^ADDR_W with no error.
- Reset (any time, including mid-drain): occ = 0, state = ACCEPT, line_addr = 0, line_valid = 0, line_last = 0, line_count = 0, line_data/line_idx = 0, in_ready = 1 from the first cycle after reset.
- Storage: circular buffer with head/tail pointers modulo DEPTH. Occupancy counter width is $clog2(DEPTH)+1.

Optional Feature:
- Macro: PACKER_STATS_EN.
- When defined, adds these outputs:
  - stat_entries (32): total entries popped.
  - stat_stall (32): cycles where |in_valid & !in_ready.
  - stat_bp (32): cycles where line_valid & !line_ready.
- All three counters reset on rst only and saturate at all-ones.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Steady stream, line_ready = 1: 4 cycles of in_valid = 4'b1111 with data 1..16 -> two lines, line_count = 8, data 1..8 then 9..16, line_addr 0 then 1, line_last = 0.
- Partial tail flush: push 3 entries (in_valid = 4'b0111) with in_flush = 1 -> in_ready = 0 next cycle; one line with line_count = 3, line_last = 1, entries 3..7 read 0, line_addr 0; then ACCEPT and in_ready = 1.
- Empty flush: in_flush = 1 with in_valid = 0, occ = 0 -> single line with line_count = 0, line_last = 1.
- Backpressure: line_ready = 0 while pushing 4 entries per cycle -> in_ready drops when occ = 16. Line outputs hold stable; no entry is lost or duplicated after line_ready is released.
- Flush spanning lines: occ = 10 plus flush with 2 more entries -> line_count 8 (last = 0), then line_count 4 (last = 1), line_addr 0 then 1.
- Reset mid-DRAIN with occ = 5 -> next cycle line_valid = 0, in_ready = 1, line_addr = 0. A subsequent 8-entry push yields a line with line_addr 0.
